gshare_update_ctrl: RTL

- Sequencer and arbiter for a single-port 2-bit-counter PHT shared between fetch-stage GShare lookups and resolution-stage counter updates.
- Owns the speculative 8-bit GHR and computes each lookup index as PC[8:1] XOR GHR.
- Tracks in-flight predictions in an in-order queue and restores the GHR and flushes the queue on a mispredict.
- Sits between the fetch unit, the branch-resolution stage and the PHT memory.

---
 rtl/gshare_update_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gshare_update_ctrl.sv
// GShare PHT sequencer: arbitrates fetch lookups against resolution-stage
// read-modify-write counter updates on a single-port PHT; owns the speculative GHR.
module gshare_update_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_req,
  input  logic [31:0]                pred_pc,
  output logic                       pred_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  output logic                       mispredict,
  output logic [IDX_W-1:0]           ghr,
  output logic [$clog2(DEPTH):0]     inflight_cnt,
  output logic                       pht_en,
  output logic                       pht_we,
  output logic [IDX_W-1:0]           pht_addr,
  output logic [1:0]                 pht_wdata,
  input  logic [1:0]                 pht_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_t;

  state_t             state, state_nxt;
  logic               lookup_pending;
  logic [IDX_W-1:0]   lk_idx, lk_snap;
  logic [IDX_W-1:0]   upd_idx;
  logic               upd_taken;
  logic [PTR_W-1:0]   head, tail;

  logic [IDX_W-1:0]   q_idx  [DEPTH];
  logic               q_pred [DEPTH];
  logic [IDX_W-1:0]   q_snap [DEPTH];

  logic               accept_pred, accept_res, head_mispred;
  logic [IDX_W-1:0]   lookup_idx;
  logic               unused_pc;

  assign unused_pc    = ^{pred_pc[31:IDX_W+1], pred_pc[0]};
  assign lookup_idx   = pred_pc[IDX_W:1] ^ ghr;
  assign head_mispred = q_pred[head] != res_taken;

  // Reset gates the handshakes so no PHT access starts while reset is held.
  assign res_ready  = !reset && (state == IDLE) && !lookup_pending && (inflight_cnt != '0);
  assign pred_ready = !reset && (state == IDLE) && !lookup_pending &&
                      (inflight_cnt < CNT_W'(DEPTH)) && !(res_valid && res_ready);
  assign accept_pred = pred_req && pred_ready;
  assign accept_res  = res_valid && res_ready;

  assign pred_valid = lookup_pending;
  assign pred_taken = lookup_pending && pht_rdata[1];

  always_comb begin
    state_nxt = state;
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    case (state)
      IDLE: begin
        if (accept_res) begin
          state_nxt = UPD_RD;
        end else if (accept_pred) begin
          pht_en   = 1'b1;
          pht_addr = lookup_idx;
        end
      end
      UPD_RD: begin
        state_nxt = UPD_WR;
        pht_en    = 1'b1;
        pht_addr  = upd_idx;
      end
      UPD_WR: begin
        state_nxt = IDLE;
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = upd_idx;
        if (upd_taken)
          pht_wdata = (pht_rdata == 2'b11) ? 2'b11 : pht_rdata + 2'b01;
        else
          pht_wdata = (pht_rdata == 2'b00) ? 2'b00 : pht_rdata - 2'b01;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lookup_pending <= 1'b0;
      lk_idx         <= '0;
      lk_snap        <= '0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      mispredict     <= 1'b0;
      ghr            <= '0;
      head           <= '0;
      tail           <= '0;
      inflight_cnt   <= '0;
    end else begin
      state          <= state_nxt;
      mispredict     <= 1'b0;
      lookup_pending <= accept_pred;
      if (accept_pred) begin
        lk_idx  <= lookup_idx;
        lk_snap <= ghr;
      end
      if (lookup_pending) begin
        tail         <= tail + PTR_W'(1);
        inflight_cnt <= inflight_cnt + CNT_W'(1);
        ghr          <= {ghr[IDX_W-2:0], pht_rdata[1]};
      end
      // Push and pop are mutually exclusive, so these updates never collide.
      if (accept_res) begin
        upd_idx   <= q_idx[head];
        upd_taken <= res_taken;
        if (head_mispred) begin
          mispredict   <= 1'b1;
          ghr          <= {q_snap[head][IDX_W-2:0], res_taken};
          head         <= '0;
          tail         <= '0;
          inflight_cnt <= '0;
        end else begin
          head         <= head + PTR_W'(1);
          inflight_cnt <= inflight_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lookup_pending) begin
      q_idx[tail]  <= lk_idx;
      q_pred[tail] <= pht_rdata[1];
      q_snap[tail] <= lk_snap;
    end
  end

endmodule
